// File: rtl/ssa_split.sv
// ssa_split: radix-4 digit splitter.
//
// Accepts a 16-bit operand and emits its eight 2-bit digits serially, least
// significant digit first. Each digit is zero-extended into an SLOT_W-bit
// slot. Both the input side and the output side use valid/ready handshakes.
// When the last digit is taken, the next operand can be accepted in the same
// cycle. With out_ready held high this gives one operand every 8 cycles.
//
// Parameters:
//   SLOT_W     width of each output digit slot (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    16-bit operand to decompose
//   in_valid   in_data is valid
//   in_ready   block accepts an operand this cycle
//   out_data   current digit, zero-extended to SLOT_W
//   out_idx    digit index 0..7 (digit k has weight 4^k)
//   out_last   high while out_idx == 7
//   out_valid  out_data/out_idx/out_last are valid
//   out_ready  downstream consumes the digit this cycle
//   busy       high while digits are being emitted
//
// Optional build macro SSA_SPLIT_PACKED_OUT_EN adds two outputs:
//   packed_out   96 bits, all eight digits in 9-bit slots, bits [95:72] zero
//   packed_valid one-cycle pulse in the cycle after an operand is accepted
module ssa_split #(
   parameter int SLOT_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SLOT_W-1:0] out_data,
   output logic [2:0]        out_idx,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
`ifdef SSA_SPLIT_PACKED_OUT_EN
   ,
   output logic [95:0]       packed_out,
   output logic              packed_valid
`endif
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t      state, state_nxt;
   logic [15:0] sreg;
   logic [2:0]  idx;
   logic        in_hs;
   logic        out_hs;

   // Handshakes and output decode. The output flags come straight from the
   // state register, so they drop in the same instant that rst asserts.
   always_comb begin
      out_valid = (state == EMIT);
      busy      = (state == EMIT);
      out_last  = (state == EMIT) && (idx == 3'd7);
      in_ready  = (state == IDLE) || ((state == EMIT) && out_last && out_ready);
      in_hs     = in_valid && in_ready;
      out_hs    = out_valid && out_ready;
      out_idx   = idx;
      // The register has been shifted empty by the time the FSM returns to
      // IDLE, so the slot reads zero there without extra gating.
      out_data      = '0;
      out_data[1:0] = sreg[1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_hs) state_nxt = EMIT;
         EMIT: if (out_hs && out_last) state_nxt = in_hs ? EMIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Digit shift register. A reload takes priority over a shift. This is
   // what lets the last digit and a new operand share one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         idx  <= '0;
      end else if (in_hs) begin
         sreg <= in_data;
         idx  <= '0;
      end else if (out_hs) begin
         sreg <= {2'b00, sreg[15:2]};
         idx  <= idx + 3'd1;
      end
   end

`ifdef SSA_SPLIT_PACKED_OUT_EN
   function automatic logic [95:0] pack_digits(input logic [15:0] op);
      logic [95:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[9*k +: 9] = {7'b0, op[2*k +: 2]};
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         packed_out   <= '0;
         packed_valid <= 1'b0;
      end else begin
         packed_valid <= in_hs;
         if (in_hs) packed_out <= pack_digits(in_data);
      end
   end
`endif

endmodule

// File: tb/tb_ssa_split.sv
// Testbench for ssa_split.
//
// A queue-based model holds the digits that are still owed to downstream.
// The compare process checks every DUT output against that model at each
// falling edge. The emitted digits are recombined into operands and compared
// with the accepted operands. The directed cases pin the model with literal
// digit sequences.
module tb_ssa_split;
   localparam int SLOT_W = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [15:0]       in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [SLOT_W-1:0] out_data;
   logic [2:0]        out_idx;
   logic              out_last;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;
`ifdef SSA_SPLIT_PACKED_OUT_EN
   logic [95:0]       packed_out;
   logic              packed_valid;
`endif

   ssa_split #(.SLOT_W(SLOT_W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
`ifdef SSA_SPLIT_PACKED_OUT_EN
      , .packed_out(packed_out), .packed_valid(packed_valid)
`endif
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [1:0]  q[$];          // digits still to be emitted for the current operand
   logic [15:0] cur_op;
   logic [15:0] exp_ops[$];    // operands whose eight digits all went out
   logic [15:0] got_ops[$];    // operands rebuilt from DUT digits
   int          n_acc = 0;
   logic        m_pv = 1'b0;
   logic [95:0] m_po = '0;
   logic        m_rdy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_pv = 1'b0;
         m_po = '0;
      end else begin
         m_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
         m_pv  = 1'b0;
         if (q.size() != 0 && out_ready) begin
            if (q.size() == 1) exp_ops.push_back(cur_op);
            void'(q.pop_front());
         end
         if (in_valid && m_rdy) begin
            cur_op = in_data;
            for (int k = 0; k < 8; k++) q.push_back(in_data[2*k +: 2]);
            n_acc++;
            m_pv = 1'b1;
            m_po = '0;
            for (int k = 0; k < 8; k++) m_po[9*k +: 9] = {7'b0, in_data[2*k +: 2]};
         end
      end
   end

   // ---------------- compare process ----------------
   int          dlog[$];
   int          busy_cnt = 0;
   int          qn;
   logic [15:0] acc = '0;

   always @(negedge clk) begin
      if (!rst) begin
         qn = q.size();
         chk("in_ready",  in_ready,  (qn == 0) || (qn == 1 && out_ready));
         chk("out_valid", out_valid, qn != 0);
         chk("busy",      busy,      qn != 0);
         chk("out_last",  out_last,  qn == 1);
         chk("out_idx",   out_idx,   (qn == 0) ? 0 : 8 - qn);
         chk("out_data",  out_data,  (qn == 0) ? 0 : q[0]);
`ifdef SSA_SPLIT_PACKED_OUT_EN
         chk("packed_valid", packed_valid, m_pv);
         chk("packed_out",   packed_out,   m_po);
`endif
         if (busy) busy_cnt++;
         if (out_valid && out_ready) begin
            dlog.push_back(int'(out_data));
            if (out_idx == 3'd0) acc = '0;
            acc = acc | (16'(out_data[1:0]) << (2 * out_idx));
            if (out_last) got_ops.push_back(acc);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [15:0] op);
      bit got;
      got = 0;
      in_valid = 1'b1;
      in_data  = op;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      chk("accept_timeout", got, 1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic check_seq(input string nm, input int base, input int e[8]);
      for (int i = 0; i < 8; i++)
         chk(nm, (base + i < dlog.size()) ? dlog[base + i] : 32'hFFFF, e[i]);
   endtask

   int seq_b4e1[8] = '{1, 0, 2, 3, 0, 1, 3, 2};
   int seq_ffff[8] = '{3, 3, 3, 3, 3, 3, 3, 3};
   int seq_0001[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
   int seq_1234[8] = '{0, 1, 3, 0, 2, 0, 1, 0};
   int seq_0003[8] = '{3, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      int target;
      int cyc;
      int nops;
`ifdef SSA_SPLIT_PACKED_OUT_EN
      logic [15:0] rec;
`endif

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy",      busy,      0);
      chk("rst_out_idx",   out_idx,   0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_in_ready",  in_ready,  1);
      #1;
      rst = 1'b0;

      // single operand, free-running sink
      dlog.delete();
      busy_cnt  = 0;
      out_ready = 1'b1;
      push(16'hB4E1);
`ifdef SSA_SPLIT_PACKED_OUT_EN
      rec = '0;
      for (int k = 0; k < 8; k++) begin
         chk("packed_slot", packed_out[9*k +: 9], seq_b4e1[k]);
         rec = rec | (16'(packed_out[9*k +: 9]) << (2 * k));
      end
      chk("packed_recombine", rec, 16'hB4E1);
      chk("packed_hi_zero", packed_out[95:72], 0);
`endif
      repeat (10) tick();
      check_seq("seq_B4E1", 0, seq_b4e1);
      chk("busy_cycles_B4E1", busy_cnt, 8);

      // back-to-back operands
      dlog.delete();
      busy_cnt = 0;
      push(16'hFFFF);
      push(16'h0001);
      repeat (10) tick();
      check_seq("seq_FFFF", 0, seq_ffff);
      check_seq("seq_0001", 8, seq_0001);
      chk("busy_cycles_b2b", busy_cnt, 16);

      // downstream stall at idx 2
      dlog.delete();
      out_ready = 1'b0;
      push(16'h1234);
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("hold_idx",   out_idx,   2);
         chk("hold_data",  out_data,  3);
         chk("hold_valid", out_valid, 1);
      end
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      repeat (8) tick();
      check_seq("seq_1234", 0, seq_1234);

      // asynchronous reset in the middle of an operand
      push(16'hABCD);
      repeat (4) tick();
      #1;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_idx",   out_idx,   0);
      chk("arst_busy",      busy,      0);
      chk("arst_out_data",  out_data,  0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready",  in_ready,  1);
      chk("post_rst_out_valid", out_valid, 0);
      repeat (2) tick();
      dlog.delete();
      push(16'h0003);
      repeat (10) tick();
      check_seq("seq_0003", 0, seq_0003);

      // random operands with random stalls
      target = n_acc + 1000;
      cyc = 0;
      while (n_acc < target && cyc < 30000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
      end
      chk("random_done", n_acc >= target, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();

      // every completed operand must come back intact, in order
      chk("ops_count", got_ops.size(), exp_ops.size());
      nops = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
      for (int i = 0; i < nops; i++) chk("recombine", got_ops[i], exp_ops[i]);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
